// File: rtl/ccc_lock_reset_seq.sv
// Fabric reset sequencer driven by the CCC LOCK output. It releases a registered,
// active-high reset once lock has been stable and a hold-off has expired.
module ccc_lock_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 256,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             lock_in_i,
  input  logic             force_rst_i,
  input  logic             clr_status_i,
  output logic             rst_out_o,
  output logic             ready_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [1:0]       state_o
);

  // state      | meaning
  // WAIT_LOCK  | reset held, waiting for synchronised lock
  // FILTER     | lock seen, counting consecutive high cycles
  // HOLD       | lock accepted, hold-off before release
  // RUN        | reset released, watching for lock loss
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_FILTER    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_base;
  logic                   lk;
  logic                   loss_evt;

  assign lk = sync_q[SYNC_STAGES-1];

  // State register, synchroniser and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_WAIT_LOCK;
      sync_q  <= '0;
      filt_q  <= '0;
      hold_q  <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], lock_in_i};
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; FORCE_RST outranks a lock drop, which outranks counting
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    if (force_rst_i) begin
      state_d = ST_WAIT_LOCK;
      filt_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (lk) begin
            state_d = ST_FILTER;
            filt_d  = FILT_W'(1);
          end
        end
        ST_FILTER: begin
          if (!lk) begin
            state_d = ST_WAIT_LOCK;
            filt_d  = '0;
          end else if (filt_q == FILT_W'(LOCK_FILTER)) begin
            state_d = ST_HOLD;
            filt_d  = '0;
            hold_d  = HOLD_W'(1);
          end else begin
            filt_d = filt_q + FILT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!lk) begin
            state_d = ST_WAIT_LOCK;
            hold_d  = '0;
          end else if (hold_q >= HOLD_W'(HOLD_CYCLES - 1)) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state_d = ST_WAIT_LOCK;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          filt_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Output logic; a loss on the same edge as a clear survives the clear
  always_comb begin
    loss_evt = (state_q == ST_RUN) && !force_rst_i && !lk;
    rst_d    = (state_d != ST_RUN);
    ready_d  = (state_d == ST_RUN);
    cnt_base = clr_status_i ? '0 : cnt_q;
    lost_d   = clr_status_i ? 1'b0 : lost_q;
    cnt_d    = cnt_base;
    if (loss_evt) begin
      lost_d = 1'b1;
      if (!(&cnt_base)) begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
  end

  assign rst_out_o   = rst_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lost_q;
  assign loss_cnt_o  = cnt_q;
  assign state_o     = state_q;

endmodule
